// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the GPU core: opcodes, mux encodings,
// instruction field positions and the pure instruction decode function.
// The decoder, PC/NZP unit, ALU and LSU all import this package.
package gpu_isa_pkg;

  // Instruction geometry
  localparam int INSTR_BITS    = 16;
  localparam int IMM_BITS      = 8;
  localparam int REG_ADDR_BITS = 4;
  localparam int NZP_BITS      = 3;

  // Field bit positions inside a fetched instruction
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int RS_MSB     = 7;
  localparam int RS_LSB     = 4;
  localparam int RT_MSB     = 3;
  localparam int RT_LSB     = 0;
  localparam int NZP_MSB    = 11;
  localparam int NZP_LSB    = 9;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_BRNZP = 4'h1,
    OP_CMP   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MUL   = 4'h5,
    OP_DIV   = 4'h6,
    OP_LDR   = 4'h7,
    OP_STR   = 4'h8,
    OP_CONST = 4'h9,
    OP_RET   = 4'hF
  } opcode_e;

  // Register file write-data source select
  localparam logic [1:0] REG_IN_ALU   = 2'd0;
  localparam logic [1:0] REG_IN_MEM   = 2'd1;
  localparam logic [1:0] REG_IN_CONST = 2'd2;

  // ALU arithmetic operation select
  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_SUB = 2'd1;
  localparam logic [1:0] ALU_OP_MUL = 2'd2;
  localparam logic [1:0] ALU_OP_DIV = 2'd3;

  // Control bundle handed to the execution units
  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] rd;
    logic [REG_ADDR_BITS-1:0] rs;
    logic [REG_ADDR_BITS-1:0] rt;
    logic [NZP_BITS-1:0]      nzp;
    logic [IMM_BITS-1:0]      immediate;
    logic                     reg_write_enable;
    logic [1:0]               reg_input_mux;
    logic [1:0]               alu_arithmetic_mux;
    logic                     alu_output_mux;
    logic                     nzp_write_enable;
    logic                     mem_read_enable;
    logic                     mem_write_enable;
    logic                     pc_mux;
    logic                     ret;
  } decoded_t;

  localparam decoded_t DECODED_NOP = '0;

  // True for every opcode the ISA defines
  function automatic logic is_legal_opcode(input logic [3:0] op);
    case (op)
      OP_NOP, OP_BRNZP, OP_CMP, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_LDR, OP_STR, OP_CONST, OP_RET: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Raw instruction to control bundle. Address, nzp and immediate fields are
  // always taken straight from the instruction bits; enables and mux selects
  // stay zero unless the opcode sets them, so illegal opcodes decode as NOP.
  function automatic decoded_t decode_fields(input logic [INSTR_BITS-1:0] instr);
    decoded_t d;
    d           = DECODED_NOP;
    d.rd        = instr[RD_MSB:RD_LSB];
    d.rs        = instr[RS_MSB:RS_LSB];
    d.rt        = instr[RT_MSB:RT_LSB];
    d.nzp       = instr[NZP_MSB:NZP_LSB];
    d.immediate = instr[IMM_MSB:IMM_LSB];
    case (instr[OPCODE_MSB:OPCODE_LSB])
      OP_BRNZP: d.pc_mux = 1'b1;
      OP_CMP: begin
        d.alu_output_mux   = 1'b1;
        d.nzp_write_enable = 1'b1;
      end
      OP_ADD: begin
        d.reg_write_enable   = 1'b1;
        d.reg_input_mux      = REG_IN_ALU;
        d.alu_arithmetic_mux = ALU_OP_ADD;
      end
      OP_SUB: begin
        d.reg_write_enable   = 1'b1;
        d.reg_input_mux      = REG_IN_ALU;
        d.alu_arithmetic_mux = ALU_OP_SUB;
      end
      OP_MUL: begin
        d.reg_write_enable   = 1'b1;
        d.reg_input_mux      = REG_IN_ALU;
        d.alu_arithmetic_mux = ALU_OP_MUL;
      end
      OP_DIV: begin
        d.reg_write_enable   = 1'b1;
        d.reg_input_mux      = REG_IN_ALU;
        d.alu_arithmetic_mux = ALU_OP_DIV;
      end
      OP_LDR: begin
        d.mem_read_enable  = 1'b1;
        d.reg_write_enable = 1'b1;
        d.reg_input_mux    = REG_IN_MEM;
      end
      OP_STR: d.mem_write_enable = 1'b1;
      OP_CONST: begin
        d.reg_write_enable = 1'b1;
        d.reg_input_mux    = REG_IN_CONST;
      end
      OP_RET:  d.ret = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  // Keep the address/immediate fields, drop every enable and mux select
  function automatic decoded_t clear_enables(input decoded_t d);
    decoded_t c;
    c           = DECODED_NOP;
    c.rd        = d.rd;
    c.rs        = d.rs;
    c.rt        = d.rt;
    c.nzp       = d.nzp;
    c.immediate = d.immediate;
    return c;
  endfunction

endpackage

// File: rtl/decoded_instruction_if.sv
// Decoded control bundle between the instruction decoder (producer) and the
// PC/NZP unit, ALU, LSU and register file (consumers).
interface decoded_instruction_if;
  import gpu_isa_pkg::*;

  logic [REG_ADDR_BITS-1:0] rd;
  logic [REG_ADDR_BITS-1:0] rs;
  logic [REG_ADDR_BITS-1:0] rt;
  logic [NZP_BITS-1:0]      nzp;
  logic [IMM_BITS-1:0]      immediate;
  logic                     reg_write_enable;
  logic [1:0]               reg_input_mux;
  logic [1:0]               alu_arithmetic_mux;
  logic                     alu_output_mux;
  logic                     nzp_write_enable;
  logic                     mem_read_enable;
  logic                     mem_write_enable;
  logic                     pc_mux;
  logic                     ret;

  modport producer (
    output rd, rs, rt, nzp, immediate,
    output reg_write_enable, reg_input_mux, alu_arithmetic_mux,
    output alu_output_mux, nzp_write_enable,
    output mem_read_enable, mem_write_enable, pc_mux, ret
  );

  modport consumer (
    input rd, rs, rt, nzp, immediate,
    input reg_write_enable, reg_input_mux, alu_arithmetic_mux,
    input alu_output_mux, nzp_write_enable,
    input mem_read_enable, mem_write_enable, pc_mux, ret
  );

endinterface

// File: rtl/instruction_decoder.sv
// Registered instruction decoder: one fetched instruction in, one control
// bundle out, one cycle of latency and one instruction per cycle throughput.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps valid and its data stable until that edge; ready
// may depend combinationally on the consumer's ready but never on valid.
// flush drops both the held bundle and whatever is offered that cycle.
module instruction_decoder
  import gpu_isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [INSTR_W-1:0]     instr,
  output logic                   instr_ready,
  input  logic                   flush,
  decoded_instruction_if.producer decoded_instruction,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic                   illegal
);

  // Only the fixed 16-bit encoding is implemented
  if (INSTR_W != INSTR_BITS || IMM_W != IMM_BITS) begin : g_bad_params
    $error("instruction_decoder supports only INSTR_W=16, IMM_W=8");
  end

  decoded_t bundle_q;
  logic     accept;

  // Ready whenever the output slot is empty or being drained this cycle
  always_comb begin
    instr_ready = !reset && !flush && (!dec_valid || dec_ready);
    accept      = instr_valid && instr_ready;
  end

  // Output bundle register, valid flag and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q  <= DECODED_NOP;
      dec_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      bundle_q  <= clear_enables(bundle_q);
      dec_valid <= 1'b0;
    end else if (accept) begin
      bundle_q  <= decode_fields(instr);
      dec_valid <= 1'b1;
      if (!is_legal_opcode(instr[OPCODE_MSB:OPCODE_LSB])) begin
        illegal <= 1'b1;
      end
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  // Drive the interface straight from the register: no path from instr
  assign decoded_instruction.rd                 = bundle_q.rd;
  assign decoded_instruction.rs                 = bundle_q.rs;
  assign decoded_instruction.rt                 = bundle_q.rt;
  assign decoded_instruction.nzp                = bundle_q.nzp;
  assign decoded_instruction.immediate          = bundle_q.immediate;
  assign decoded_instruction.reg_write_enable   = bundle_q.reg_write_enable;
  assign decoded_instruction.reg_input_mux      = bundle_q.reg_input_mux;
  assign decoded_instruction.alu_arithmetic_mux = bundle_q.alu_arithmetic_mux;
  assign decoded_instruction.alu_output_mux     = bundle_q.alu_output_mux;
  assign decoded_instruction.nzp_write_enable   = bundle_q.nzp_write_enable;
  assign decoded_instruction.mem_read_enable    = bundle_q.mem_read_enable;
  assign decoded_instruction.mem_write_enable   = bundle_q.mem_write_enable;
  assign decoded_instruction.pc_mux             = bundle_q.pc_mux;
  assign decoded_instruction.ret                = bundle_q.ret;

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Registered instruction decoder that turns one 16-bit fetched instruction into the control bundle consumed by the PC/NZP unit, ALU, LSU and register file. Sits between the fetcher and the per-thread execution units in each core. It is the producer end of `decoded_instruction_if`. A valid/ready handshake on both sides gives one instruction per cycle throughput with one cycle of latency, plus flush and sticky illegal-opcode reporting.

## Interface

Clocking: reset reset, synchronous, active-high; clock clk.

Parameters:
- INSTR_W, 16, instruction width (fixed encoding below; other values unsupported).
- IMM_W, 8, immediate / branch-target width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  fetcher presents an instruction.
- instr  in  INSTR_W  raw instruction.
- instr_ready  out  1  decoder accepts `instr` this cycle.
- flush  in  1  discard held and incoming instruction (taken branch / kernel abort).
- decoded_instruction  `decoded_instruction_if.producer`  —  registered control bundle (fields below).
- dec_valid  out  1  bundle is valid.
- dec_ready  in  1  downstream consumes the bundle this cycle.
- illegal  out  1  sticky; set on the first illegal opcode decoded.

## Operation

Encoding: opcode = instr[15:12], rd = [11:8], rs = [7:4], rt = [3:0], nzp = [11:9], immediate = [7:0].

Opcodes:
- 0x0 NOP: all enables 0.
- 0x1 BRnzp: pc_mux=1, nzp field driven.
- 0x2 CMP: alu_output_mux=1, nzp_write_enable=1.
- 0x3 ADD / 0x4 SUB / 0x5 MUL / 0x6 DIV: reg_write_enable=1, reg_input_mux=ALU(0), alu_arithmetic_mux=0/1/2/3.
- 0x7 LDR: mem_read_enable=1, reg_write_enable=1, reg_input_mux=MEM(1).
- 0x8 STR: mem_write_enable=1.
- 0x9 CONST: reg_write_enable=1, reg_input_mux=CONST(2).
- 0xF RET: ret=1.
- Anything else is illegal. It decodes as NOP (all enables 0) with `illegal` set; `dec_valid` still asserts so the pipeline drains.

Field rules:
- Address, nzp and immediate fields are always driven from the raw bits, regardless of opcode.
- Enable and mux fields are zero unless the opcode listed above sets them.

Handshake and flush:
- instr_ready = !reset && !flush && (!dec_valid || dec_ready).
- Accept when instr_valid && instr_ready. The bundle register loads and dec_valid=1 next cycle.
- On dec_valid && dec_ready with no accept, dec_valid clears next cycle.
- Consume and accept in the same cycle: the register reloads and dec_valid stays 1.
- While dec_valid && !dec_ready, the bundle and dec_valid hold stable. Downstream may rely on this.
- flush: dec_valid=0 next cycle, no accept that cycle, and all bundle enables clear to 0. Flush takes priority over a simultaneous dec_ready.
- illegal sets on accepting an illegal opcode and clears only on reset.

## Timing

- Reset values: dec_valid=0, illegal=0, every bundle field 0 (NOP), instr_ready=0 during reset.
- Latency: accept at edge N gives the bundle visible after edge N, i.e. one cycle.
- Throughput: 1 instruction per cycle while dec_ready stays high.
- Reset asserted mid-stream drops the held bundle with no partial output.
- Back-pressure: instr_ready falls combinationally the same cycle dec_ready is low with dec_valid high.
- No combinational path from instr to any bundle output.

## Structure

Shared package `gpu_isa_pkg` holds:
- the opcode enum;
- reg_input_mux encodings ALU/MEM/CONST;
- alu_arithmetic_mux encodings ADD/SUB/MUL/DIV;
- field bit-position constants;
- a pure `decode_fields` function (instr → bundle struct).

The PC unit, ALU and LSU reuse these constants. No sub-module: one sequential always block plus the package function. `decoded_instruction_if` gains a `producer` modport if it is absent.

## Test plan

- Reset, then ADD R3,R1,R2 (0x3312), dec_ready=1 → after 1 cycle: dec_valid=1, rd=3, rs=1, rt=2, reg_write_enable=1, reg_input_mux=0, alu_arithmetic_mux=0, all other enables 0.
- BRn 0x05 (0x1805) → pc_mux=1, nzp=3'b100, immediate=0x05. CMP R1,R2 (0x2012) → nzp_write_enable=1, alu_output_mux=1.
- Back-to-back stream: CONST R4,#0x7F (0x947F), LDR, STR, RET (0xF000), dec_ready=1 → four consecutive dec_valid cycles. CONST gives reg_input_mux=2, immediate=0x7F. RET gives ret=1.
- Hold dec_ready=0 for 3 cycles with instr_valid=1 → bundle stable, instr_ready=0. Release → next instruction appears 1 cycle later with none lost or duplicated.
- Assert flush while dec_valid=1 and dec_ready=1 → dec_valid=0 next cycle, the incoming instruction is not accepted, and enables are 0.
- Illegal 0xA000 → NOP bundle with dec_valid=1 and illegal=1. illegal stays 1 through later legal instructions and clears only on reset.
